// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I word type, line/beat widths and line-adapter FSM states
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    localparam int LINE_WIDTH = 256;
    localparam int BEAT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } pmem_state_e;

endpackage

// File: rtl/pmem_line_adapter.sv
// rtl/pmem_line_adapter.sv - L2 line to physical-memory burst adapter (256-bit line <-> 4 x 64-bit beats)
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   line_read, line_write           L2 fill / writeback requests, held until line_resp
//   line_address, line_wdata        request address and victim line
//   line_rdata, line_resp           assembled fill line, one-cycle completion pulse
//   burst_read, burst_write         burst commands to memory
//   burst_address                   line-aligned burst address
//   burst_wdata, burst_rdata        outgoing / incoming 64-bit beat
//   burst_resp                      one beat accepted/valid per high cycle
module pmem_line_adapter
    import rv32i_types::*;
#(
    parameter int BEATS    = 4,
    parameter int s_offset = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_read,
    input  logic                  line_write,
    input  rv32i_word             line_address,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  line_resp,
    output logic                  burst_read,
    output logic                  burst_write,
    output rv32i_word             burst_address,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    pmem_state_e             state_q;
    logic [1:0]              cnt_q;
    logic [31-s_offset:0]    addr_q;
    logic [LINE_WIDTH-1:0]   buf_q;
    logic                    burst_read_q;
    logic                    burst_write_q;
    logic                    line_resp_q;

    // Byte-offset bits of the request address never reach memory.
    logic unused_offset;
    assign unused_offset = ^line_address[s_offset-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            buf_q         <= '0;
            burst_read_q  <= 1'b0;
            burst_write_q <= 1'b0;
            line_resp_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Writeback has priority so a dirty victim leaves before its fill.
                    if (line_write) begin
                        buf_q         <= line_wdata;
                        addr_q        <= line_address[31:s_offset];
                        cnt_q         <= '0;
                        burst_write_q <= 1'b1;
                        state_q       <= WR_BURST;
                    end else if (line_read) begin
                        addr_q        <= line_address[31:s_offset];
                        cnt_q         <= '0;
                        burst_read_q  <= 1'b1;
                        state_q       <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (burst_resp) begin
                        buf_q[{cnt_q, 6'b0} +: BEAT_WIDTH] <= burst_rdata;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == LAST_BEAT) begin
                            burst_read_q <= 1'b0;
                            line_resp_q  <= 1'b1;
                            state_q      <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (burst_resp) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == LAST_BEAT) begin
                            burst_write_q <= 1'b0;
                            line_resp_q   <= 1'b1;
                            state_q       <= DONE;
                        end
                    end
                end
                DONE: begin
                    line_resp_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign burst_read    = burst_read_q;
    assign burst_write   = burst_write_q;
    assign line_resp     = line_resp_q;
    assign line_rdata    = buf_q;
    assign burst_address = (state_q == IDLE) ? '0 : {addr_q, {s_offset{1'b0}}};
    assign burst_wdata   = (state_q == WR_BURST) ? buf_q[{cnt_q, 6'b0} +: BEAT_WIDTH] : '0;

endmodule

// File: tb/tb_pmem_line_adapter.sv
// tb/tb_pmem_line_adapter.sv - scoreboard bench for pmem_line_adapter
module tb_pmem_line_adapter;

    logic         clk;
    logic         rst_n;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_address;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int vectors;
    int miscompares;

    logic [255:0] exp_q[$];

    pmem_line_adapter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .line_read    (line_read),
        .line_write   (line_write),
        .line_address (line_address),
        .line_wdata   (line_wdata),
        .line_rdata   (line_rdata),
        .line_resp    (line_resp),
        .burst_read   (burst_read),
        .burst_write  (burst_write),
        .burst_address(burst_address),
        .burst_wdata  (burst_wdata),
        .burst_rdata  (burst_rdata),
        .burst_resp   (burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a complete read with 'gap' idle cycles before each beat.
    // Returns what was observed; callers do the comparisons.
    task automatic run_read(input logic [31:0] addr, input logic [255:0] line, input int gap,
                            output logic [255:0] rdata, output int resp_cnt, output int rd_low,
                            output logic [31:0] addr_seen, output int resp_on_time, output int idle_busy);
        resp_cnt = 0; rd_low = 0; rdata = '0; addr_seen = '0; resp_on_time = 0; idle_busy = 0;
        line_read = 1'b1;
        line_address = addr;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                burst_resp = 1'b0;
                burst_rdata = 64'hDEAD_BEEF_0000_0000 | 64'(g);
                @(negedge clk);
                if (!burst_read) rd_low++;
                if (line_resp) resp_cnt++;
                if (k == 0 && g == 0) addr_seen = burst_address;
                @(posedge clk); #1;
            end
            burst_resp = 1'b1;
            burst_rdata = line[k*64 +: 64];
            @(negedge clk);
            if (!burst_read) rd_low++;
            if (line_resp) resp_cnt++;
            if (k == 0 && gap == 0) addr_seen = burst_address;
            @(posedge clk); #1;
        end
        burst_resp = 1'b0;
        burst_rdata = '0;
        @(negedge clk);
        if (line_resp) begin
            resp_cnt++;
            resp_on_time = 1;
            rdata = line_rdata;
        end
        @(posedge clk); #1;
        line_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (line_resp) resp_cnt++;
            if (burst_read || burst_write) idle_busy++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({line_resp, burst_read, burst_write} !== 3'b000 || burst_address !== 32'h0 ||
            line_rdata !== 256'h0 || burst_wdata !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: resp/rd/wr=%b addr=%h wdata=%h required all zero",
                     {line_resp, burst_read, burst_write}, burst_address, burst_wdata);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // burst_resp while idle must not touch the buffer
        burst_resp = 1'b1;
        burst_rdata = 64'h5555_AAAA_5555_AAAA;
        repeat (2) @(posedge clk);
        #1 burst_resp = 1'b0;
        @(negedge clk);
        vectors++;
        if (line_rdata !== 256'h0 || line_resp !== 1'b0 || burst_read !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_resp_ignored: rdata=%h resp=%b rd=%b required 0", line_rdata, line_resp, burst_read);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        logic [255:0] line, got, exp;
        logic [31:0] a;
        int rc, rl, ot, ib;
        line = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        exp_q.push_back(line);
        run_read(32'h1234_5678, line, 0, got, rc, rl, a, ot, ib);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL read_data: got %h required %h", got, exp); end
        vectors++;
        if (a !== 32'h1234_5660) begin miscompares++; $display("FAIL read_addr: got %h required 12345660", a); end
        vectors++;
        if (rc !== 1 || ot !== 1) begin miscompares++; $display("FAIL read_resp: count %0d on_time %0d required 1 1", rc, ot); end
        vectors++;
        if (rl !== 0) begin miscompares++; $display("FAIL read_cmd_held: low cycles %0d required 0", rl); end
    endtask

    task automatic test_write();
        logic [255:0] wd;
        logic [63:0] wq[$];
        logic [63:0] e;
        int wr_low, resp_cnt;
        wr_low = 0; resp_cnt = 0;
        wd = {64'hD3D3_0000_3333_FFFF, 64'hD2D2_1111_2222_EEEE, 64'hD1D1_2222_1111_DDDD, 64'hD0D0_3333_0000_CCCC};
        for (int k = 0; k < 4; k++) wq.push_back(wd[k*64 +: 64]);
        line_write = 1'b1;
        line_wdata = wd;
        line_address = 32'h8000_00FF;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (burst_address !== 32'h8000_00E0) begin
            miscompares++; $display("FAIL write_addr: got %h required 800000e0", burst_address);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < 2; g++) begin
                burst_resp = 1'b0;
                @(negedge clk);
                vectors++;
                if (burst_wdata !== wq[0]) begin
                    miscompares++; $display("FAIL write_stall_beat%0d: got %h required %h", k, burst_wdata, wq[0]);
                end
                if (!burst_write) wr_low++;
                @(posedge clk); #1;
            end
            burst_resp = 1'b1;
            @(negedge clk);
            e = wq.pop_front();
            vectors++;
            if (burst_wdata !== e) begin
                miscompares++; $display("FAIL write_beat%0d: got %h required %h", k, burst_wdata, e);
            end
            if (!burst_write) wr_low++;
            if (line_resp) resp_cnt++;
            @(posedge clk); #1;
        end
        burst_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (line_resp) resp_cnt++;
            @(posedge clk); #1;
            line_write = 1'b0;
        end
        vectors++;
        if (resp_cnt !== 1 || wr_low !== 0) begin
            miscompares++; $display("FAIL write_resp: resp %0d cmd_low %0d required 1 0", resp_cnt, wr_low);
        end
    endtask

    task automatic test_stalls();
        logic [255:0] line, got, exp;
        logic [31:0] a;
        int rc, rl, ot, ib;
        int gaps[3] = '{0, 3, 7};
        line = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h1111_2222_3333_4444, 64'h9999_8888_7777_6666};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(line);
            run_read(32'h0000_1000, line, gaps[i], got, rc, rl, a, ot, ib);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp || rc !== 1 || rl !== 0) begin
                miscompares++;
                $display("FAIL stall_gap%0d: data %h resp %0d cmd_low %0d required %h 1 0", gaps[i], got, rc, rl, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        int resp_cnt, rd_high;
        resp_cnt = 0; rd_high = 0;
        line_read = 1'b1;
        line_write = 1'b1;
        line_wdata = {64'h4, 64'h3, 64'h2, 64'h1};
        line_address = 32'h0000_2020;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (burst_write !== 1'b1 || burst_read !== 1'b0) begin
            miscompares++; $display("FAIL simul_cmd: wr=%b rd=%b required 1 0", burst_write, burst_read);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            burst_resp = 1'b1;
            @(negedge clk);
            vectors++;
            if (burst_wdata !== 64'(k + 1)) begin
                miscompares++; $display("FAIL simul_beat%0d: got %h required %0d", k, burst_wdata, k + 1);
            end
            if (burst_read) rd_high++;
            @(posedge clk); #1;
        end
        burst_resp = 1'b0;
        @(negedge clk);
        if (line_resp) resp_cnt++;
        @(posedge clk); #1;
        line_read = 1'b0;
        line_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (resp_cnt !== 1 || rd_high !== 0) begin
            miscompares++; $display("FAIL simul_done: resp %0d rd_high %0d required 1 0", resp_cnt, rd_high);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [255:0] line, got, exp;
        logic [31:0] a;
        int rc, rl, ot, ib, late_resp;
        late_resp = 0;
        line_read = 1'b1;
        line_address = 32'h0000_0040;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            burst_resp = 1'b1;
            burst_rdata = 64'hC0 + 64'(k);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({burst_read, burst_write, line_resp} !== 3'b000 || burst_address !== 32'h0 || line_rdata !== 256'h0) begin
            miscompares++;
            $display("FAIL reset_mid: rd/wr/resp=%b addr=%h rdata=%h required zero",
                     {burst_read, burst_write, line_resp}, burst_address, line_rdata);
        end
        burst_resp = 1'b0;
        line_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (line_resp) late_resp++;
        end
        vectors++;
        if (late_resp !== 0) begin miscompares++; $display("FAIL reset_no_resp: resp %0d required 0", late_resp); end
        @(posedge clk); #1;
        line = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
        exp_q.push_back(line);
        run_read(32'h0000_0040, line, 1, got, rc, rl, a, ot, ib);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp || rc !== 1) begin
            miscompares++; $display("FAIL reset_recover: data %h resp %0d required %h 1", got, rc, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] l1, l2, got, exp;
        logic [31:0] a;
        int rc, rl, ot, ib;
        l1 = {64'h13, 64'h12, 64'h11, 64'h10};
        l2 = {64'h23, 64'h22, 64'h21, 64'h20};
        exp_q.push_back(l1);
        run_read(32'h0000_3000, l1, 0, got, rc, rl, a, ot, ib);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp || rc !== 1 || ib !== 0) begin
            miscompares++; $display("FAIL b2b_first: data %h resp %0d idle_busy %0d required %h 1 0", got, rc, ib, exp);
        end
        exp_q.push_back(l2);
        run_read(32'h0000_3020, l2, 0, got, rc, rl, a, ot, ib);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp || rc !== 1 || a !== 32'h0000_3020) begin
            miscompares++; $display("FAIL b2b_second: data %h resp %0d addr %h required %h 1 00003020", got, rc, a, exp);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        line_read = 1'b0;
        line_write = 1'b0;
        line_address = '0;
        line_wdata = '0;
        burst_rdata = '0;
        burst_resp = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_stalls();
        test_simultaneous();
        test_reset_mid_burst();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pmem_line_adapter.md
PMEM_LINE_ADAPTER -- requirements
Module: pmem_line_adapter

Interface
REQ-001 SHALL have parameter BEATS, default 4, giving the number of 64-bit beats per 256-bit line.
REQ-002 SHALL have parameter s_offset, default 5, giving the number of line-offset address bits that are forced to zero on burst_address.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 line_read  input  1  L2 line-fill request; held high until line_resp.
REQ-006 line_write  input  1  L2 writeback request; held high until line_resp.
REQ-007 line_address  input  32  rv32i_word line address from the L2 address mux.
REQ-008 line_wdata  input  256  victim line to write back.
REQ-009 line_rdata  output  256  assembled fill line.
REQ-010 line_resp  output  1  one-cycle completion pulse.
REQ-011 burst_read  output  1  burst read command to physical memory.
REQ-012 burst_write  output  1  burst write command to physical memory.
REQ-013 burst_address  output  32  line-aligned burst address.
REQ-014 burst_wdata  output  64  current write beat.
REQ-015 burst_rdata  input  64  current read beat.
REQ-016 burst_resp  input  1  memory beat-accepted/beat-valid strobe, one beat per high cycle.

Function
REQ-017 The FSM SHALL have the states IDLE, RD_BURST, WR_BURST and DONE.
REQ-018 Requests SHALL be sampled only in IDLE; line_read and line_write while in RD_BURST, WR_BURST or DONE SHALL be ignored.
REQ-019 In IDLE with line_write=1, the block SHALL latch line_wdata into the line buffer and line_address[31:s_offset] into the address register, zero the beat counter, and enter WR_BURST; line_write SHALL win if line_read is also high.
REQ-020 In IDLE with only line_read=1, the block SHALL latch the address, zero the beat counter, and enter RD_BURST.
REQ-021 burst_address SHALL be {latched tag/index, s_offset zeros}, stable for the whole burst, and 0 in IDLE.
REQ-022 burst_read SHALL be high exactly while in RD_BURST, and burst_write exactly while in WR_BURST; both SHALL be registered (no combinational path from line_*).
REQ-023 In RD_BURST, each cycle with burst_resp=1 SHALL store burst_rdata into buffer bits [64*cnt+63 : 64*cnt] and increment cnt (beat 0 = bits 63:0).
REQ-024 In WR_BURST, burst_wdata SHALL equal buffer bits [64*cnt+63 : 64*cnt]; each cycle with burst_resp=1 SHALL increment cnt.
REQ-025 cnt SHALL be 2 bits wide and wrap from 3 to 0 on the final beat; the final beat (cnt=BEATS-1 with burst_resp=1) SHALL move the FSM to DONE.
REQ-026 burst_resp=0 cycles SHALL stall the burst without limit, with no state change.
REQ-027 DONE SHALL last exactly one cycle with line_resp=1, then return unconditionally to IDLE.
REQ-028 line_rdata SHALL equal the buffer contents at all times: valid in DONE after a read, and holding the last contents until the next burst modifies the buffer.
REQ-029 burst_resp in IDLE or DONE SHALL be ignored.
REQ-030 Minimum latency with memory responding every cycle: request seen at edge 0, burst command high in cycles 1-4, line_resp in cycle 5.

Reset
REQ-031 rst_n=0 SHALL immediately force the FSM to IDLE, cnt=0, address register=0, line buffer=0, and all outputs to 0, including when asserted mid-burst.
REQ-032 A burst aborted by reset SHALL NOT produce line_resp, and the first edge after deassertion SHALL sample requests as in IDLE.

Structure
REQ-033 rv32i_word SHALL come from rv32i_types; the LINE_WIDTH (256) and BEAT_WIDTH (64) constants and the FSM state enum SHALL be added to rv32i_types.
REQ-034 No sub-module is required; the buffer, counter and FSM SHALL be implemented inline in a single module.

Verification
REQ-035 Read: line_read=1 at address 0x1234_5678 with beats 0xA0..A3 on consecutive burst_resp -> burst_address=0x1234_5660; line_resp in cycle 5; line_rdata={A3,A2,A1,A0}.
REQ-036 Write: line_write=1 with line_wdata={D3,D2,D1,D0} -> burst_wdata sequence D0,D1,D2,D3, each advancing only on burst_resp; one line_resp pulse.
REQ-037 Stalls: read with burst_resp gaps of 0, 3 and 7 cycles between beats -> identical line_rdata; burst_read held throughout; exactly one line_resp.
REQ-038 Simultaneous request: line_read=line_write=1 in IDLE -> WR_BURST is taken and burst_read stays 0.
REQ-039 Reset mid-burst: rst_n=0 after beat 2 of a read -> outputs 0 immediately, no line_resp; a following read completes correctly.
REQ-040 Back-to-back: client drops the request the cycle after line_resp, then issues a new one -> no double service; the second burst starts with cnt=0.
